// File: rtl/mul_seq.sv
// mul_seq: round-robin arbiter and sequencer for the shift-add multiplier.
// Loads a granted operand pair, waits STEPS cycles, captures the product.
module mul_seq #(
   parameter int W     = 4,
   parameter int STEPS = 4,
   parameter int CW    = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0,
   input  logic [W-1:0]    a0,
   input  logic [W-1:0]    b0,
   input  logic            req1,
   input  logic [W-1:0]    a1,
   input  logic [W-1:0]    b1,
   output logic            gnt0,
   output logic            gnt1,
   output logic            mul_ld,
   output logic [W-1:0]    mul_a,
   output logic [W-1:0]    mul_b,
   input  logic [2*W-1:0]  mul_ry,
   output logic            busy,
   output logic            done,
   output logic            done_id,
   output logic [2*W-1:0]  result,
   output logic [CW-1:0]   ops_cnt,
   output logic [1:0]      state
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      RUN  = 2'b10,
      DONE = 2'b11
   } state_t;

   localparam int SW = $clog2(STEPS + 1);
   localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

   state_t        st;
   logic [SW-1:0] step;
   logic          rr;
   logic          id;
   logic          pick0;
   logic          pick1;

   // on a tie the requester not named by rr wins
   always_comb begin
      pick0 = req0 & (~req1 | rr);
      pick1 = req1 & (~req0 | ~rr);
   end

   assign gnt0  = (st == IDLE) & pick0;
   assign gnt1  = (st == IDLE) & pick1;
   assign busy  = (st != IDLE);
   assign state = st;

   // sequencer: grant, load, step, capture
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st      <= IDLE;
         step    <= '0;
         rr      <= 1'b1;
         id      <= 1'b0;
         mul_ld  <= 1'b0;
         mul_a   <= '0;
         mul_b   <= '0;
         done    <= 1'b0;
         done_id <= 1'b0;
         result  <= '0;
         ops_cnt <= '0;
      end else begin
         done   <= 1'b0;
         mul_ld <= 1'b0;
         unique case (st)
            IDLE: begin
               if (pick0 | pick1) begin
                  if (req0 & req1) rr <= pick1;
                  id     <= pick1;
                  mul_a  <= pick1 ? a1 : a0;
                  mul_b  <= pick1 ? b1 : b0;
                  mul_ld <= 1'b1;
                  st     <= LOAD;
               end
            end
            LOAD: begin
               step <= '0;
               st   <= RUN;
            end
            RUN: begin
               step <= step + 1'b1;
               if (step == LAST) st <= DONE;
            end
            DONE: begin
               result  <= mul_ry;
               done    <= 1'b1;
               done_id <= id;
               ops_cnt <= ops_cnt + 1'b1;
               st      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: mul_seq driving a behavioural shift-add multiplier,
// checked every cycle against a transaction-level model.
module tb_mul_seq;

   localparam int W     = 4;
   localparam int STEPS = 4;
   localparam int CW    = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            req0 = 1'b0;
   logic            req1 = 1'b0;
   logic [W-1:0]    a0 = '0;
   logic [W-1:0]    b0 = '0;
   logic [W-1:0]    a1 = '0;
   logic [W-1:0]    b1 = '0;
   logic            gnt0;
   logic            gnt1;
   logic            mul_ld;
   logic [W-1:0]    mul_a;
   logic [W-1:0]    mul_b;
   logic [2*W-1:0]  mul_ry;
   logic            busy;
   logic            done;
   logic            done_id;
   logic [2*W-1:0]  result;
   logic [CW-1:0]   ops_cnt;
   logic [1:0]      state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mul_seq #(.W(W), .STEPS(STEPS), .CW(CW)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .a0(a0), .b0(b0),
      .req1(req1), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1),
      .mul_ld(mul_ld), .mul_a(mul_a), .mul_b(mul_b),
      .mul_ry(mul_ry),
      .busy(busy), .done(done), .done_id(done_id),
      .result(result), .ops_cnt(ops_cnt), .state(state)
   );

   // multiplier stand-in: after load, one more multiplier bit per cycle
   logic [W-1:0] ra;
   logic [W-1:0] rb;
   int           mcnt;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         ra   <= '0;
         rb   <= '0;
         mcnt <= STEPS;
      end else if (mul_ld) begin
         ra   <= mul_a;
         rb   <= mul_b;
         mcnt <= 0;
      end else if (mcnt < STEPS) begin
         mcnt <= mcnt + 1;
      end
   end

   always_comb begin
      mul_ry = (2*W)'(int'(ra) * (int'(rb) & ((1 << mcnt) - 1)));
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int code_of(input int age);
      if (age == 0) return 0;
      if (age == 1) return 1;
      if (age <= STEPS + 1) return 2;
      return 3;
   endfunction

   // transaction model: age = cycles since the grant of the op in flight
   int           age   = 0;
   logic [W-1:0] m_a   = '0;
   logic [W-1:0] m_b   = '0;
   bit           m_id  = 1'b0;
   bit           m_rr  = 1'b1;
   bit           m_dn  = 1'b0;
   bit           m_did = 1'b0;
   int           m_res = 0;
   int           m_cnt = 0;

   always @(negedge clk) begin
      bit eg0;
      bit eg1;
      if (!rst) begin
         chk("rst_gnt0", gnt0, 0);
         chk("rst_gnt1", gnt1, 0);
         chk("rst_ld", mul_ld, 0);
         chk("rst_a", mul_a, 0);
         chk("rst_b", mul_b, 0);
         chk("rst_done", done, 0);
         chk("rst_did", done_id, 0);
         chk("rst_res", result, 0);
         chk("rst_cnt", ops_cnt, 0);
         chk("rst_state", state, 0);
         chk("rst_busy", busy, 0);
         age = 0; m_a = '0; m_b = '0; m_id = 0; m_rr = 1;
         m_dn = 0; m_did = 0; m_res = 0; m_cnt = 0;
      end else begin
         eg0 = 0;
         eg1 = 0;
         if (age == 0 && (req0 || req1)) begin
            if (req0 && req1) begin
               if (m_rr) eg0 = 1; else eg1 = 1;
            end else if (req0) eg0 = 1;
            else eg1 = 1;
         end
         chk("gnt0", gnt0, eg0);
         chk("gnt1", gnt1, eg1);
         chk("busy", busy, age != 0);
         chk("mul_ld", mul_ld, age == 1);
         chk("state", state, code_of(age));
         chk("mul_a", mul_a, m_a);
         chk("mul_b", mul_b, m_b);
         chk("done", done, m_dn);
         chk("done_id", done_id, m_did);
         chk("result", result, m_res);
         chk("ops_cnt", ops_cnt, m_cnt);
         m_dn = 0;
         if (age == STEPS + 2) begin
            m_dn  = 1;
            m_did = m_id;
            m_res = int'(m_a) * int'(m_b);
            m_cnt = (m_cnt + 1) % (1 << CW);
            age   = 0;
         end else if (age != 0) begin
            age++;
         end else if (eg0 || eg1) begin
            if (req0 && req1) m_rr = eg1;
            m_id = eg1;
            m_a  = eg1 ? a1 : a0;
            m_b  = eg1 ? b1 : b0;
            age  = 1;
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      req0 = 0; req1 = 0; rst = 0;
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      rst = 1;
   endtask

   task automatic do_op(input bit id, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_res,
                        input string nm);
      int k;
      @(posedge clk); #1;
      if (id) begin req1 = 1; a1 = a; b1 = b; end
      else begin req0 = 1; a0 = a; b0 = b; end
      k = 0;
      do begin @(negedge clk); k++; end
      while (!(id ? gnt1 : gnt0) && k < 40);
      chk({nm, "_gnt"}, id ? gnt1 : gnt0, 1);
      @(posedge clk); #1;
      if (id) req1 = 0; else req0 = 0;
      k = 0;
      do begin @(negedge clk); k++; end
      while (!done && k < 40);
      chk({nm, "_lat"}, k, 7);
      chk({nm, "_res"}, result, exp_res);
      chk({nm, "_id"}, done_id, id);
   endtask

   initial begin
      int k;
      int g;
      int dn;
      int w0;
      int w1;
      int cy;
      bit s0;
      bit s1;

      do_reset();

      // F*F from requester 0
      do_op(0, 4'hF, 4'hF, 8'hE1, "ff");
      chk("ff_cnt", ops_cnt, 1);

      // simultaneous requests, second granted in the done cycle
      @(posedge clk); #1;
      a0 = 3; b0 = 5; a1 = 7; b1 = 6;
      req0 = 1; req1 = 1;
      @(negedge clk);
      chk("tie_gnt0", gnt0, 1);
      @(posedge clk); #1;
      req0 = 0;
      k = 0;
      do begin @(negedge clk); k++; end
      while (!done && k < 40);
      chk("tie_res0", result, 8'h0F);
      chk("tie_b2b", gnt1, 1);
      @(posedge clk); #1;
      req1 = 0;
      k = 0;
      do begin @(negedge clk); k++; end
      while (!done && k < 40);
      chk("tie_lat1", k, 7);
      chk("tie_res1", result, 8'h2A);
      chk("tie_id1", done_id, 1);

      // both held for four ops: alternation and 7-cycle spacing
      do_reset();
      a0 = 2; b0 = 3; a1 = 5; b1 = 4;
      req0 = 1; req1 = 1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         k = 0;
         while (!(gnt0 || gnt1) && k < 40) begin
            @(negedge clk);
            k++;
         end
         chk("alt_gnt", gnt1, i % 2);
         if (i > 0) chk("alt_b2b", k, 0);
         if (i == 3) begin
            @(posedge clk); #1;
            req0 = 0; req1 = 0;
         end
         k = 0;
         do begin @(negedge clk); k++; end
         while (!done && k < 40);
         chk("alt_lat", k, 7);
         chk("alt_id", done_id, i % 2);
         chk("alt_res", result, (i % 2) ? 8'h14 : 8'h06);
      end

      // zero operand and unit multiplier
      do_op(1, 4'h0, 4'h9, 8'h00, "zero");
      do_op(1, 4'h9, 4'h1, 8'h09, "unit");

      // reset in the second RUN cycle aborts the op
      @(posedge clk); #1;
      req0 = 1; a0 = 4'hD; b0 = 4'hB;
      k = 0;
      do begin @(negedge clk); k++; end
      while (!gnt0 && k < 40);
      @(posedge clk); #1;
      req0 = 0;
      @(posedge clk);
      @(posedge clk); #2;
      rst = 0;
      #1;
      chk("abort_state", state, 0);
      chk("abort_busy", busy, 0);
      chk("abort_res", result, 0);
      chk("abort_cnt", ops_cnt, 0);
      chk("abort_a", mul_a, 0);
      chk("abort_done", done, 0);
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1;
      repeat (10) begin
         @(negedge clk);
         chk("abort_nodone", done, 0);
      end
      do_op(0, 4'h6, 4'h7, 8'h2A, "post");
      chk("post_cnt", ops_cnt, 1);

      // random traffic through the counter wrap
      do_reset();
      g = 0; dn = 0; w0 = 0; w1 = 0; cy = 0;
      while (dn < 258 && cy < 6000) begin
         @(negedge clk);
         cy++;
         s0 = gnt0;
         s1 = gnt1;
         if (done) begin
            dn++;
            if (dn == 255) chk("wrap_ff", ops_cnt, 8'hFF);
            if (dn == 256) chk("wrap_00", ops_cnt, 8'h00);
         end
         w0 = (req0 && !s0) ? w0 + 1 : 0;
         w1 = (req1 && !s1) ? w1 + 1 : 0;
         if (w0 == 25) chk("starve0", w0, 24);
         if (w1 == 25) chk("starve1", w1, 24);
         @(posedge clk); #1;
         if (s0) begin
            req0 = 0;
            g++;
         end else if (req0 && $urandom_range(0, 15) == 0) begin
            req0 = 0;
         end else if (!req0 && $urandom_range(0, 3) == 0) begin
            req0 = 1;
            a0 = W'($urandom);
            b0 = W'($urandom);
         end
         if (s1) begin
            req1 = 0;
            g++;
         end else if (req1 && $urandom_range(0, 15) == 0) begin
            req1 = 0;
         end else if (!req1 && $urandom_range(0, 3) == 0) begin
            req1 = 1;
            a1 = W'($urandom);
            b1 = W'($urandom);
         end
      end
      chk("rand_ops", dn >= 258, 1);
      chk("rand_gnts", g >= dn, 1);
      req0 = 0;
      req1 = 0;
      repeat (12) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
